// File: rtl/store_buffer_fwd.sv
// Speculative store buffer: circular FIFO of stores with a commit pointer, in-order drain of
// committed entries, youngest-entry coalescing and byte-granular youngest-wins load forwarding.
module store_buffer_fwd #(
  parameter int SB_DEPTH   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int COALESCE   = 1,
  localparam int NB = DATA_WIDTH / 8,
  localparam int CW = $clog2(SB_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  enq_valid_i,
  output logic                  enq_ready_o,
  input  logic [ADDR_WIDTH-1:0] enq_addr_i,
  input  logic [DATA_WIDTH-1:0] enq_data_i,
  input  logic [NB-1:0]         enq_strb_i,
  input  logic                  enq_uncached_i,
  input  logic                  commit_i,
  output logic                  deq_valid_o,
  input  logic                  deq_ready_i,
  output logic [ADDR_WIDTH-1:0] deq_addr_o,
  output logic [DATA_WIDTH-1:0] deq_data_o,
  output logic [NB-1:0]         deq_strb_o,
  output logic                  deq_uncached_o,
  input  logic [ADDR_WIDTH-1:0] fwd_addr_i,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic [NB-1:0]         fwd_hit_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int IW = $clog2(SB_DEPTH);
  localparam int PW = IW + 1;
  localparam int OW = $clog2(NB);
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [IW-1:0] I_ONE = 1;

  logic [SB_DEPTH-1:0]   r_vld, r_cmtd, r_unc;
  logic [ADDR_WIDTH-1:0] r_addr [SB_DEPTH];
  logic [DATA_WIDTH-1:0] r_data [SB_DEPTH];
  logic [NB-1:0]         r_strb [SB_DEPTH];
  logic [PW-1:0]         r_head, r_tail, r_cmt;

  logic [IW-1:0] w_hidx, w_tidx, w_cidx, w_yidx;
  logic          w_empty, w_full, w_has_unc, w_cmt_fire, w_coal_ok;
  logic          w_enq, w_push, w_merge, w_deq;

  assign w_hidx = r_head[IW-1:0];
  assign w_tidx = r_tail[IW-1:0];
  assign w_cidx = r_cmt[IW-1:0];
  assign w_yidx = w_tidx - I_ONE;

  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_hidx == w_tidx) && (r_head[IW] != r_tail[IW]);
  assign w_has_unc  = (r_cmt != r_tail);
  assign w_cmt_fire = commit_i & w_has_unc;

  // The youngest entry may only absorb a store if it stays uncommitted through this edge.
  assign w_coal_ok = (COALESCE != 0) && !w_empty && w_has_unc
                   && !(w_cmt_fire && ((r_cmt + P_ONE) == r_tail))
                   && !r_unc[w_yidx] && !enq_uncached_i
                   && (r_addr[w_yidx][ADDR_WIDTH-1:OW] == enq_addr_i[ADDR_WIDTH-1:OW]);

  assign enq_ready_o = !w_full | w_coal_ok;
  assign w_enq   = enq_valid_i & enq_ready_o & !flush_i;
  assign w_merge = w_enq & w_coal_ok;
  assign w_push  = w_enq & !w_coal_ok;

  assign deq_valid_o    = r_vld[w_hidx] & r_cmtd[w_hidx];
  assign deq_addr_o     = r_addr[w_hidx];
  assign deq_data_o     = r_data[w_hidx];
  assign deq_strb_o     = r_strb[w_hidx];
  assign deq_uncached_o = r_unc[w_hidx];
  assign w_deq          = deq_valid_o & deq_ready_i;

  assign count_o = CW'(r_tail - r_head);
  assign full_o  = w_full;
  assign empty_o = w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_cmtd <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cmt  <= '0;
    end else begin
      if (w_cmt_fire) begin
        r_cmtd[w_cidx] <= 1'b1;
        r_cmt          <= r_cmt + P_ONE;
      end
      if (w_deq) begin
        r_vld[w_hidx]  <= 1'b0;
        r_cmtd[w_hidx] <= 1'b0;
        r_head         <= r_head + P_ONE;
      end
      // Flush keeps whatever is committed, including the entry committed this very edge.
      if (flush_i) begin
        for (int i = 0; i < SB_DEPTH; i++)
          if (r_vld[i] && !r_cmtd[i] && !(w_cmt_fire && (w_cidx == IW'(i))))
            r_vld[i] <= 1'b0;
        r_tail <= w_cmt_fire ? (r_cmt + P_ONE) : r_cmt;
      end else if (w_push) begin
        r_vld[w_tidx]  <= 1'b1;
        r_cmtd[w_tidx] <= 1'b0;
        r_tail         <= r_tail + P_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[w_tidx] <= enq_addr_i;
      r_data[w_tidx] <= enq_data_i;
      r_strb[w_tidx] <= enq_strb_i;
      r_unc[w_tidx]  <= enq_uncached_i;
    end else if (w_merge) begin
      for (int b = 0; b < NB; b++)
        if (enq_strb_i[b]) r_data[w_yidx][8*b +: 8] <= enq_data_i[8*b +: 8];
      r_strb[w_yidx] <= r_strb[w_yidx] | enq_strb_i;
    end
  end

  // Walk oldest to youngest so younger matching entries overwrite older bytes.
  always_comb begin
    logic [IW-1:0] idx;
    idx        = '0;
    fwd_hit_o  = '0;
    fwd_data_o = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = w_hidx + IW'(k);
      if (r_vld[idx] && (r_addr[idx][ADDR_WIDTH-1:OW] == fwd_addr_i[ADDR_WIDTH-1:OW]))
        for (int b = 0; b < NB; b++)
          if (r_strb[idx][b]) begin
            fwd_hit_o[b]          = 1'b1;
            fwd_data_o[8*b +: 8]  = r_data[idx][8*b +: 8];
          end
    end
  end

  a_commit_has_target: assert property (@(posedge clk) disable iff (rst) commit_i |-> w_has_unc);

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed bench for store_buffer_fwd: hand-computed expectations checked with immediate assertions.
module tb_store_buffer_fwd;
  logic        clk = 1'b0;
  logic        rst, flush_i, enq_valid_i, enq_ready_o, enq_uncached_i, commit_i;
  logic        deq_valid_o, deq_ready_i, deq_uncached_o, full_o, empty_o;
  logic [31:0] enq_addr_i, enq_data_i, deq_addr_o, deq_data_o, fwd_addr_i, fwd_data_o;
  logic [3:0]  enq_strb_i, deq_strb_o, fwd_hit_o, count_o;
  int n_err = 0;
  int n_chk = 0;

  store_buffer_fwd dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_addr_i(enq_addr_i),
    .enq_data_i(enq_data_i), .enq_strb_i(enq_strb_i), .enq_uncached_i(enq_uncached_i),
    .commit_i(commit_i), .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_addr_o(deq_addr_o), .deq_data_o(deq_data_o), .deq_strb_o(deq_strb_o),
    .deq_uncached_o(deq_uncached_o), .fwd_addr_i(fwd_addr_i), .fwd_data_o(fwd_data_o),
    .fwd_hit_o(fwd_hit_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic u);
    enq_valid_i = 1'b1; enq_addr_i = a; enq_data_i = d; enq_strb_i = s; enq_uncached_i = u;
    tick();
    enq_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush_i = 0; enq_valid_i = 0; enq_addr_i = 0; enq_data_i = 0; enq_strb_i = 0;
    enq_uncached_i = 0; commit_i = 0; deq_ready_i = 0; fwd_addr_i = 32'h1000;
    tick(); tick();
    chk("rst_ready", enq_ready_o, 1);
    chk("rst_dvalid", deq_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_hit", fwd_hit_o, 0);
    chk("rst_fdata", fwd_data_o, 0);
    rst = 1'b0;
    tick();

    // 1: enqueue, commit, drain
    enq(32'h1000, 32'hAABBCCDD, 4'hF, 0);
    chk("t1_count", count_o, 1);
    chk("t1_dvalid_pre", deq_valid_o, 0);
    commit_i = 1; tick(); commit_i = 0;
    chk("t1_dvalid", deq_valid_o, 1);
    chk("t1_ddata", deq_data_o, 32'hAABBCCDD);
    deq_ready_i = 1; tick(); deq_ready_i = 0;
    chk("t1_empty", empty_o, 1);

    // 2: coalescing into the youngest uncommitted entry
    enq(32'h2000, 32'h00000011, 4'b0001, 0);
    enq(32'h2002, 32'h00330000, 4'b0100, 0);
    chk("t2_count", count_o, 1);
    chk("t2_strb", deq_strb_o, 4'b0101);
    fwd_addr_i = 32'h2000; #1;
    chk("t2_hit", fwd_hit_o, 4'b0101);
    chk("t2_fdata", fwd_data_o, 32'h00330011);
    flush_i = 1; tick(); flush_i = 0;
    chk("t2_flush_empty", empty_o, 1);

    // 3: fill, commit three, flush the rest, drain in order
    for (int i = 0; i < 8; i++) enq(32'h5100 + 32'h100 * i, i, 4'hF, 0);
    chk("t3_full", full_o, 1);
    chk("t3_count8", count_o, 8);
    enq_valid_i = 1; enq_addr_i = 32'h9000; #1;
    chk("t3_ready_full", enq_ready_o, 0);
    enq_valid_i = 0;
    for (int i = 0; i < 3; i++) begin commit_i = 1; tick(); end
    commit_i = 0;
    flush_i = 1; tick(); flush_i = 0;
    chk("t3_count3", count_o, 3);
    deq_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_dvalid", deq_valid_o, 1);
      chk("t3_daddr", deq_addr_o, 32'h5100 + 32'h100 * i);
      tick();
    end
    deq_ready_i = 0;
    chk("t3_empty", empty_o, 1);

    // 4: youngest wins across a committed entry
    enq(32'h3000, 32'h00000001, 4'b0001, 0);
    commit_i = 1; tick(); commit_i = 0;
    enq(32'h3000, 32'h00000002, 4'b0001, 0);
    chk("t4_count", count_o, 2);
    fwd_addr_i = 32'h3000; #1;
    chk("t4_hit", fwd_hit_o, 4'b0001);
    chk("t4_fdata", fwd_data_o, 32'h00000002);
    commit_i = 1; tick(); commit_i = 0;
    deq_ready_i = 1; tick(); tick(); deq_ready_i = 0;
    chk("t4_empty", empty_o, 1);

    // 5: full with simultaneous deq refuses a new word, retry succeeds
    for (int i = 0; i < 8; i++) enq(32'h6000 + 32'h10 * i, 32'h100 + i, 4'hF, 0);
    commit_i = 1; tick(); commit_i = 0;
    chk("t5_full", full_o, 1);
    enq_valid_i = 1; enq_addr_i = 32'h7000; enq_data_i = 32'h77; enq_strb_i = 4'hF;
    deq_ready_i = 1; #1;
    chk("t5_ready0", enq_ready_o, 0);
    tick(); deq_ready_i = 0;
    chk("t5_count7", count_o, 7);
    chk("t5_ready1", enq_ready_o, 1);
    tick(); enq_valid_i = 0;
    chk("t5_count8", count_o, 8);
    flush_i = 1; tick(); flush_i = 0;
    chk("t5_flush_empty", empty_o, 1);

    // 6: uncached entry blocks merging but forwards; async reset mid-cycle
    enq(32'h4000, 32'h12345678, 4'hF, 1);
    enq(32'h4000, 32'h9ABCDEF0, 4'b0011, 0);
    chk("t6_count", count_o, 2);
    fwd_addr_i = 32'h4000; #1;
    chk("t6_hit", fwd_hit_o, 4'hF);
    chk("t6_fdata", fwd_data_o, 32'h1234DEF0);
    commit_i = 1; tick(); commit_i = 0;
    chk("t6_dvalid", deq_valid_o, 1);
    chk("t6_dunc", deq_uncached_o, 1);
    #2 rst = 1'b1; #1;
    chk("t6_rst_count", count_o, 0);
    chk("t6_rst_dvalid", deq_valid_o, 0);
    chk("t6_rst_hit", fwd_hit_o, 0);
    tick(); rst = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
